// File: rtl/score_display_scanner.sv
// score_display_scanner: formats game state into a scanned digit display.
// Result messages are held for HOLD cycles and blink while shown.
module score_display_scanner #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8,
  parameter int HOLD      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic [3:0]        round,
  input  logic [3:0]        win,
  input  logic [3:0]        lose,
  input  logic [3:0]        p1_black,
  input  logic [3:0]        p1_white,
  input  logic [3:0]        p2_black,
  input  logic [3:0]        p2_white,
  input  logic [1:0]        matchresult,
  input  logic [1:0]        gameresult,
  output logic [4*NDIG-1:0] word,
  output logic [NDIG-1:0]   digit_en,
  output logic [3:0]        digit_val,
  output logic              busy,
  output logic              frame_tick
);
  localparam int WW = 4 * NDIG;
  localparam int IW = $clog2(NDIG);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int HW = $clog2(HOLD + 1);
  logic [15:0]   base, mr_pat, gr_pat;
  logic [WW-1:0] fmt, word_q, word_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    prev_q;
  logic          src_q, src_d, is_res, entry;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d, ft_q, tc, wrap, bwrap;
  assign mr_pat = matchresult == 2'd0 ? 16'hFFFF : matchresult == 2'd1 ? 16'h7B3D :
                  matchresult == 2'd2 ? 16'h5878 : 16'h5874;
  assign gr_pat = gameresult == 2'd0 ? 16'hFFFF : gameresult == 2'd1 ? 16'hFF3D :
                  gameresult == 2'd2 ? 16'hFF78 : 16'hFF74;
  always_comb begin
    base = 16'hFFFF;
    case (state)
      3'd0: base = 16'h1A1F;
      3'd1: base = {round, 4'hF, win, lose};
      3'd2: base = {p1_black, p1_white, p2_black, p2_white};
      3'd3: base = 16'h1FFF;
      3'd4: base = 16'h2FFF;
      3'd5: base = mr_pat;
      3'd6: base = gr_pat;
      default: base = 16'hFFFF;
    endcase
  end
  // Base word in the top four digits; shifting in zeros then inverting blanks the rest.
  assign fmt    = ~(WW'(~base) << (WW - 16));
  assign is_res = state == 3'd5 || state == 3'd6;
  assign busy   = hold_q != '0;
  assign entry  = !busy && is_res && prev_q != state;
  assign word_d = busy ? word_q : fmt;
  assign src_d  = busy ? src_q : is_res;
  assign hold_d = busy ? hold_q - 1'b1 : entry ? HW'(HOLD) : '0;
  assign tc      = presc_q == PW'(SCAN_DIV - 1);
  assign wrap    = tc && idx_q == IW'(NDIG - 1);
  assign bwrap   = wrap && bcnt_q == BW'(BLINK_DIV - 1);
  assign presc_d = tc ? '0 : presc_q + 1'b1;
  assign idx_d   = !tc ? idx_q : wrap ? '0 : idx_q + 1'b1;
  assign bcnt_d  = entry ? '0 : !wrap ? bcnt_q : bwrap ? '0 : bcnt_q + 1'b1;
  assign blink_d = entry ? 1'b1 : bwrap ? ~blink_q : blink_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '1;
      hold_q  <= '0;
      src_q   <= 1'b0;
      prev_q  <= 3'd0;
      presc_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      word_q  <= word_d;
      hold_q  <= hold_d;
      src_q   <= src_d;
      prev_q  <= state;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      ft_q    <= wrap;
    end
  end
  assign word       = word_q;
  assign frame_tick = ft_q;
  assign digit_en   = NDIG'(1) << idx_q;
  assign digit_val  = (src_q && !blink_q) ? 4'hF : word_q[{idx_q, 2'b00} +: 4];
endmodule
